// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared VRAM widths and arbiter state encoding.
package vram_arbiter_pkg;
    localparam int VRAM_ADDR_WIDTH = 14;
    localparam int VRAM_DATA_WIDTH = 8;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RDWAIT = 2'd1,
        ST_ACK    = 2'd2
    } state_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: video fetch and CPU bus signals seen by the VRAM arbiter.
interface vram_arbiter_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8
);
    logic                  vid_req;
    logic [ADDR_WIDTH-1:0] vid_addr;
    logic                  vid_valid;
    logic [DATA_WIDTH-1:0] vid_rdata;
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_starved;
    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  vid_valid, vid_rdata, cpu_ack, cpu_rdata, cpu_starved
    );
    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output vid_valid, vid_rdata, cpu_ack, cpu_rdata, cpu_starved
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a 1-cycle-latency single-port VRAM between the video fetcher (absolute priority) and a CPU port.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = VRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH   = VRAM_DATA_WIDTH,
    parameter int STARVE_LIMIT = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    vram_arbiter_if.slave         bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_wen,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          issue;
    assign issue = state == ST_IDLE && bus.cpu_req && !bus.vid_req;
    assign ram_din = bus.cpu_wdata;
    assign bus.vid_rdata = ram_dout;
    always_ff @(posedge clk) begin
        state <= reset ? ST_IDLE : nxt;
    end
    always_comb begin
        nxt = state == ST_RDWAIT ? ST_ACK :
              state == ST_ACK    ? ST_IDLE :
              issue              ? (bus.cpu_we ? ST_ACK : ST_RDWAIT) : ST_IDLE;
    end
    always_comb begin
        ram_addr    = bus.vid_req ? bus.vid_addr : bus.cpu_addr;
        ram_wen     = !reset && issue && bus.cpu_we;
        bus.cpu_ack = state == ST_ACK;
    end
    // Wait counter only moves while a request sits in IDLE; it is already zero by the time RDWAIT/ACK are reached.
    always_comb begin
        cnt_nxt = state != ST_IDLE ? cnt :
                  (bus.cpu_req && bus.vid_req) ? (cnt == CW'(STARVE_LIMIT) ? cnt : cnt + 1'b1) : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt             <= '0;
            bus.cpu_starved <= 1'b0;
            bus.vid_valid   <= 1'b0;
            bus.cpu_rdata   <= '0;
        end else begin
            cnt             <= cnt_nxt;
            bus.cpu_starved <= bus.cpu_starved | (cnt_nxt == CW'(STARVE_LIMIT));
            bus.vid_valid   <= bus.vid_req;
            if (state == ST_RDWAIT) bus.cpu_rdata <= ram_dout;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed stimulus with a queue scoreboard checked by a negedge monitor.
module tb_vram_arbiter;
    typedef struct {
        logic       rd;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    logic        clk;
    logic        reset;
    logic [13:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_wen;
    logic [7:0]  ram_dout;
    logic [7:0]  mem [0:16383];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        cpu_q[$];
    exp_t        vid_q[$];

    vram_arbiter_if #(.ADDR_WIDTH(14), .DATA_WIDTH(8)) bus ();

    vram_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .STARVE_LIMIT(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_wen  (ram_wen),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM, read-old-data, 1-cycle read latency
    initial for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (ram_wen) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cpu(input logic rd, input logic [7:0] d, input int c);
        exp_t e;
        e.rd = rd; e.data = d; e.cyc = c;
        cpu_q.push_back(e);
    endtask

    task automatic push_vid(input logic [7:0] d, input int c);
        exp_t e;
        e.rd = 1'b1; e.data = d; e.cyc = c;
        vid_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus.cpu_ack) begin
            if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 1, 0);
            else begin
                exp_t e;
                e = cpu_q.pop_front();
                chk("cpu_ack_cycle", cyc, e.cyc);
                if (e.rd) chk("cpu_rdata", {24'h0, bus.cpu_rdata}, {24'h0, e.data});
            end
        end
        if (bus.vid_valid) begin
            if (vid_q.size() == 0) chk("vid_valid_unexpected", 1, 0);
            else begin
                exp_t e;
                e = vid_q.pop_front();
                chk("vid_valid_cycle", cyc, e.cyc);
                chk("vid_rdata", {24'h0, bus.vid_rdata}, {24'h0, e.data});
            end
        end
    end

    // Access with video idle: ack one cycle after a write issue, two after a read issue
    task automatic cpu_access(input logic we, input logic [13:0] a, input logic [7:0] d, input logic [7:0] exp);
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        push_cpu(!we, exp, cyc + (we ? 1 : 2));
        @(negedge clk);
        chk("issue_wen", {31'h0, ram_wen}, {31'h0, we});
        repeat (we ? 1 : 2) step();
        @(negedge clk);
        chk("ack_cycle_wen", {31'h0, ram_wen}, 0);
        step();
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.vid_req = 1'b0; bus.vid_addr = '0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0010; bus.cpu_wdata = 8'hFF;
        step();
        @(negedge clk);
        chk("reset_wen", {31'h0, ram_wen}, 0);
        step();
        bus.cpu_req = 1'b0; bus.vid_req = 1'b1;
        step();
        @(negedge clk);
        chk("reset_vid_valid", {31'h0, bus.vid_valid}, 0);
        chk("reset_cpu_ack", {31'h0, bus.cpu_ack}, 0);
        chk("reset_cpu_rdata", {24'h0, bus.cpu_rdata}, 0);
        chk("reset_starved", {31'h0, bus.cpu_starved}, 0);
        step();
        reset = 1'b0; bus.vid_req = 1'b0;
        step();
        step();
        cpu_access(1'b1, 14'h0123, 8'h5A, 8'h00);
        cpu_access(1'b0, 14'h0123, 8'h00, 8'h5A);
        // CPU write held under 20 cycles of continuous video fetch
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0200; bus.cpu_wdata = 8'h77;
        for (int k = 1; k <= 20; k++) begin
            bus.vid_req = 1'b1; bus.vid_addr = 14'h0123;
            push_vid(8'h5A, cyc + 1);
            @(negedge clk);
            chk("contend_wen", {31'h0, ram_wen}, 0);
            if (k == 8) chk("starved_cycle8", {31'h0, bus.cpu_starved}, 0);
            if (k == 9) chk("starved_cycle9", {31'h0, bus.cpu_starved}, 1);
            step();
        end
        bus.vid_req = 1'b0;
        push_cpu(1'b0, 8'h00, cyc + 1);
        @(negedge clk);
        chk("gap_write_wen", {31'h0, ram_wen}, 1);
        step();
        step();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("starved_sticky", {31'h0, bus.cpu_starved}, 1);
        step();
        // Read pending while video alternates; video read in the RDWAIT cycle
        cpu_access(1'b1, 14'h0300, 8'hC3, 8'h00);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0300;
        bus.vid_req = 1'b1; bus.vid_addr = 14'h0123;
        push_vid(8'h5A, cyc + 1);
        step();
        bus.vid_req = 1'b0;
        push_cpu(1'b1, 8'hC3, cyc + 2);
        @(negedge clk);
        chk("gap_read_addr", {18'h0, ram_addr}, 32'h0300);
        step();
        bus.vid_req = 1'b1; bus.vid_addr = 14'h0200;
        push_vid(8'h77, cyc + 1);
        @(negedge clk);
        chk("rdwait_vid_addr", {18'h0, ram_addr}, 32'h0200);
        step();
        bus.vid_req = 1'b0;
        step();
        bus.cpu_req = 1'b0;
        step();
        // Reset in the RDWAIT cycle drops the read
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0123;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("midreset_ack", {31'h0, bus.cpu_ack}, 0);
        chk("midreset_rdata", {24'h0, bus.cpu_rdata}, 0);
        chk("midreset_starved", {31'h0, bus.cpu_starved}, 0);
        step();
        step();
        cpu_access(1'b0, 14'h0123, 8'h00, 8'h5A);
        // Video read right after a CPU write sees the new value
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0040; bus.cpu_wdata = 8'hE1;
        push_cpu(1'b0, 8'h00, cyc + 1);
        @(negedge clk);
        chk("raw_write_wen", {31'h0, ram_wen}, 1);
        step();
        bus.vid_req = 1'b1; bus.vid_addr = 14'h0040;
        push_vid(8'hE1, cyc + 1);
        step();
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("vid_q_drained", vid_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
